// File: rtl/compress_pkg.sv
// Shared types and widths for the compression datapath.
package compress_pkg;

    localparam int WORD_W = 64;
    localparam int LINE_W = 128;

    typedef enum logic [1:0] {UNP_IDLE, UNP_LOW, UNP_HIGH} unpack_state_t;

endpackage

// File: rtl/word_unpack2.sv
// Splits one TOTAL_WIDTH line into two WORD_WIDTH words (lower half first)
// across two valid/ready handshakes, with single-half and end-of-block support.
module word_unpack2
    import compress_pkg::*;
#(
    parameter int TOTAL_WIDTH = LINE_W,
    parameter int WORD_WIDTH  = WORD_W,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [TOTAL_WIDTH-1:0] i_line,
    input  logic                   i_last,
    input  logic                   i_single,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WORD_WIDTH-1:0]  o_word,
    output logic                   o_half,
    output logic                   o_last,
    output logic                   o_busy,
    output logic [CNT_WIDTH-1:0]   o_line_count
);

    generate
        if (TOTAL_WIDTH != 2 * WORD_WIDTH) begin : g_width_check
            $error("word_unpack2: TOTAL_WIDTH must equal 2*WORD_WIDTH");
        end
    endgenerate

    unpack_state_t           state, state_d;
    logic [TOTAL_WIDTH-1:0]  line_q;
    logic                    last_q;
    logic                    single_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    final_beat;
    logic                    accept;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state;
        o_word  = '0;
        o_valid = (state != UNP_IDLE);
        o_half  = (state == UNP_HIGH);
        o_busy  = (state != UNP_IDLE);

        case (state)
            UNP_LOW:  o_word = line_q[WORD_WIDTH-1:0];
            UNP_HIGH: o_word = line_q[TOTAL_WIDTH-1:WORD_WIDTH];
            default:  o_word = '0;
        endcase

        final_beat = o_valid & i_ready &
                     ((state == UNP_HIGH) | ((state == UNP_LOW) & single_q));
        o_last     = o_valid & last_q & ((state == UNP_HIGH) | single_q);
        o_ready    = (state == UNP_IDLE) | final_beat;
        accept     = i_valid & o_ready;

        case (state)
            UNP_IDLE: state_d = UNP_IDLE;
            UNP_LOW:  if (i_ready) state_d = single_q ? UNP_IDLE : UNP_HIGH;
            UNP_HIGH: if (i_ready) state_d = UNP_IDLE;
            default:  state_d = UNP_IDLE;
        endcase

        // A line accepted on its predecessor's final beat starts with no bubble.
        if (accept) state_d = UNP_LOW;
    end

    // NOTE: the line register is reset too, so o_word reads zero until the first capture.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= UNP_IDLE;
            line_q   <= '0;
            last_q   <= 1'b0;
            single_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                line_q   <= i_line;
                last_q   <= i_last;
                single_q <= i_single;
            end
            if (final_beat) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_line_count = cnt_q;

endmodule

// File: tb/tb_word_unpack2.sv
// Scoreboard bench for word_unpack2: vector table plus stall, wrap and reset sequences.
module tb_word_unpack2;
    import compress_pkg::*;

    localparam int TW = 128;
    localparam int WW = 64;
    localparam int CW = 4;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_last = 1'b0;
    logic          i_single = 1'b0;
    logic          i_ready = 1'b0;
    logic [TW-1:0] i_line = '0;
    logic          o_ready, o_valid, o_half, o_last, o_busy;
    logic [WW-1:0] o_word;
    logic [CW-1:0] o_line_count;

    word_unpack2 #(.TOTAL_WIDTH(TW), .WORD_WIDTH(WW), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_line(i_line), .i_last(i_last), .i_single(i_single), .o_valid(o_valid),
        .i_ready(i_ready), .o_word(o_word), .o_half(o_half), .o_last(o_last),
        .o_busy(o_busy), .o_line_count(o_line_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [WW-1:0] word;
        logic          half;
        logic          last;
        logic          fin;
    } beat_t;

    typedef struct {
        logic [TW-1:0] line;
        logic          last;
        logic          single;
        logic [WW-1:0] exp_lo;
        logic [WW-1:0] exp_hi;
    } vec_t;

    beat_t         sb[$];
    int            n_vec = 0;
    int            n_bad = 0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_line(input logic last, input logic single,
                             input logic [WW-1:0] lo, input logic [WW-1:0] hi);
        beat_t b;
        b.word = lo; b.half = 1'b0; b.last = last & single; b.fin = single;
        sb.push_back(b);
        if (!single) begin
            b.word = hi; b.half = 1'b1; b.last = last; b.fin = 1'b1;
            sb.push_back(b);
        end
    endtask

    // One clock: drive, compare against the scoreboard head, then advance to the next negedge.
    task automatic step(input logic v, input logic [TW-1:0] line, input logic last,
                        input logic single, input logic [WW-1:0] lo, input logic [WW-1:0] hi,
                        input logic r, output logic acc);
        beat_t b;
        logic  exp_rdy;
        i_valid = v; i_line = line; i_last = last; i_single = single; i_ready = r;
        #1;
        exp_rdy = (sb.size() == 0) || (sb.size() == 1 && r);
        check("line_count", o_line_count, exp_cnt);
        check("o_valid", o_valid, sb.size() != 0);
        check("o_busy", o_busy, sb.size() != 0);
        check("o_ready", o_ready, exp_rdy);
        if (sb.size() != 0) begin
            check("o_word", o_word, sb[0].word);
            check("o_half", o_half, sb[0].half);
            check("o_last", o_last, sb[0].last);
            if (r) begin
                b = sb.pop_front();
                if (b.fin) exp_cnt++;
            end
        end else begin
            check("idle_word", o_word, '0);
        end
        acc = v && o_ready;
        if (acc) push_line(last, single, lo, hi);
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic offer(input logic [TW-1:0] line, input logic last, input logic single,
                         input logic [WW-1:0] lo, input logic [WW-1:0] hi, input logic r);
        logic acc;
        int   guard;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 40) begin
            step(1'b1, line, last, single, lo, hi, r, acc);
            guard++;
        end
        if (!acc) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: got no accept, expected accept within 40 cycles");
        end
    endtask

    task automatic offer_rand(input logic single, input logic last);
        logic [TW-1:0] l;
        l = {$urandom, $urandom, $urandom, $urandom};
        offer(l, last, single, l[WW-1:0], l[TW-1:WW], 1'b1);
    endtask

    task automatic drain();
        logic acc;
        int   guard;
        guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, acc);
            guard++;
        end
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, acc);
        if (sb.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", sb.size());
        end
    endtask

    vec_t tbl[6];

    initial begin
        logic acc;
        logic [TW-1:0] la, lb;

        tbl[0] = '{{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, 1'b0, 1'b0,
                   64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};
        tbl[1] = '{{64'hFFFF_0000_FFFF_0000, 64'h0000_0000_0000_1234}, 1'b1, 1'b1,
                   64'h0000_0000_0000_1234, 64'h0};
        tbl[2] = '{{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}, 1'b1, 1'b0,
                   64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        tbl[3] = '{{64'hDEAD_BEEF_DEAD_BEEF, 64'h0000_0000_0000_00FF}, 1'b0, 1'b1,
                   64'h0000_0000_0000_00FF, 64'h0};
        tbl[4] = '{{64'h8000_0000_0000_0001, 64'h0000_0000_0000_0000}, 1'b0, 1'b0,
                   64'h0000_0000_0000_0000, 64'h8000_0000_0000_0001};
        tbl[5] = '{{64'h1111_2222_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_4444};

        // Reset state, observed while reset is held.
        repeat (2) @(negedge i_clk);
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_ready", o_ready, 1'b1);
        check("rst_word", o_word, '0);
        check("rst_half", o_half, 1'b0);
        check("rst_last", o_last, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_count", o_line_count, '0);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);

        // Table vectors offered back to back with the sink always ready.
        for (int i = 0; i < 6; i++)
            offer(tbl[i].line, tbl[i].last, tbl[i].single, tbl[i].exp_lo, tbl[i].exp_hi, 1'b1);
        drain();

        // Four full lines offered continuously.
        for (int i = 0; i < 4; i++) offer_rand(1'b0, i == 3);
        drain();

        // Stall in LOW for 5 cycles and HIGH for 3 while the next line waits upstream.
        la = {$urandom, $urandom, $urandom, $urandom};
        lb = {$urandom, $urandom, $urandom, $urandom};
        offer(la, 1'b0, 1'b0, la[WW-1:0], la[TW-1:WW], 1'b1);
        repeat (5) step(1'b1, lb, 1'b1, 1'b0, lb[WW-1:0], lb[TW-1:WW], 1'b0, acc);
        step(1'b1, lb, 1'b1, 1'b0, lb[WW-1:0], lb[TW-1:WW], 1'b1, acc);
        repeat (3) step(1'b1, lb, 1'b1, 1'b0, lb[WW-1:0], lb[TW-1:WW], 1'b0, acc);
        offer(lb, 1'b1, 1'b0, lb[WW-1:0], lb[TW-1:WW], 1'b1);
        drain();

        // Seventeen single lines back to back: counter wraps through 15 -> 0 -> 1.
        for (int i = 0; i < 17; i++) offer_rand(1'b1, i[0]);
        drain();

        // Reset while the upper half is presented.
        la = {$urandom, $urandom, $urandom, $urandom};
        offer(la, 1'b1, 1'b0, la[WW-1:0], la[TW-1:WW], 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, acc);
        i_ready = 1'b0;
        i_reset = 1'b0;
        #1;
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_count", o_line_count, '0);
        check("midrst_busy", o_busy, 1'b0);
        sb.delete();
        exp_cnt = '0;
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        lb = {$urandom, $urandom, $urandom, $urandom};
        offer(lb, 1'b0, 1'b0, lb[WW-1:0], lb[TW-1:WW], 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/word_unpack2.md
Name: word_unpack2

Overview:
- Read-side counterpart of the two-half register array in the compression datapath.
- Accepts one TOTAL_WIDTH line over a valid/ready handshake and emits it as two WORD_WIDTH words, lower half first, then upper half, over a second valid/ready handshake.
- Supports single-half lines, end-of-block marking, and back-to-back lines with no bubble.
- Sits between the Stage-3 line buffer and the 64-bit output packer.

Parameters:
- TOTAL_WIDTH, 128, input line width; must equal 2*WORD_WIDTH (elaboration-time assertion).
- WORD_WIDTH, 64, output word width.
- CNT_WIDTH, 16, width of the emitted-line counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_valid  input  1  upstream line valid.
- o_ready  output  1  block can accept a line this cycle.
- i_line  input  TOTAL_WIDTH  line data; [WORD_WIDTH-1:0] is emitted first.
- i_last  input  1  line is the final line of the block.
- i_single  input  1  only the lower half is meaningful; the upper half is not emitted.
- o_valid  output  1  output word valid.
- i_ready  input  1  downstream accepts the word.
- o_word  output  WORD_WIDTH  current half.
- o_half  output  1  0 = lower half, 1 = upper half.
- o_last  output  1  final word of a line flagged i_last.
- o_busy  output  1  a line is held (state != IDLE).
- o_line_count  output  CNT_WIDTH  number of lines fully emitted.

Behaviour:
- Registers:
  - line_q holds the accepted line.
  - last_q and single_q hold the line flags.
  - state is one of IDLE, LOW, HIGH.
  - cnt_q is the emitted-line counter.
- Reset values (asynchronous, active-low): state=IDLE, line_q=0, last_q=0, single_q=0, cnt_q=0.
  - Resulting outputs: o_valid=0, o_word=0, o_half=0, o_last=0, o_busy=0, o_line_count=0, o_ready=1 after reset release.
- Output decode (combinational from registers only):
  - o_valid = (state != IDLE).
  - o_half = (state == HIGH).
  - o_word = line_q lower half in LOW, upper half in HIGH, 0 in IDLE.
- final_beat = o_valid & i_ready & ((state==HIGH) | (state==LOW & single_q)).
- o_last = o_valid & last_q & ((state==HIGH) | single_q).
- o_ready = (state==IDLE) | final_beat. The combinational path from i_ready to o_ready is accepted.
- Accept: i_valid & o_ready.
  - Captures i_line, i_last and i_single.
  - Next state is LOW.
  - Accepting on a final_beat overrides the return to IDLE.
- Transitions:
  - IDLE: accept -> LOW; otherwise stay.
  - LOW: i_ready & !single_q -> HIGH; i_ready & single_q -> IDLE, or LOW if accept.
  - LOW or HIGH with i_ready=0: hold. o_word, o_half and o_last stay stable.
  - HIGH: i_ready -> IDLE, or LOW if accept.
- Latency and throughput:
  - A line accepted at cycle N presents its lower half at N+1.
  - Full-line throughput is 2 cycles/line; single lines take 1 cycle/line with no bubbles.
- Counter:
  - cnt_q increments by 1 on each final_beat.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no saturation.
- Upstream protocol: i_valid may drop without acceptance; the block never captures when o_ready=0.
- Reset mid-line: the held line is discarded, the counter clears, and no partial word is emitted after release.
- A downstream stall in either half is unlimited; no data is lost or duplicated.

Decomposition:
- Shared package compress_pkg gains:
  - typedef enum logic [1:0] {UNP_IDLE, UNP_LOW, UNP_HIGH} unpack_state_t;
  - localparams WORD_W=64 and LINE_W=128.
- Single module. A sub-module is not natural; the half mux is inline.

Test Plan:
- Basic: line 0xAAAA...AAAA_5555...5555 with i_ready=1 -> o_word 0x5555...5555 (o_half=0) at N+1, then 0xAAAA...AAAA (o_half=1) at N+2, o_line_count=1.
- Back-to-back: 4 lines offered continuously with i_ready=1 -> 8 words on consecutive cycles, o_ready high every other cycle, o_line_count=4.
- Stall: i_ready=0 for 5 cycles in LOW and 3 cycles in HIGH -> o_word/o_half stable, o_ready=0, no capture of the next line, correct order after release.
- Single/last: i_single=1, i_last=1, line 0x...0000_0000_0000_1234 -> one word 0x1234 with o_last=1, o_half=0; next line accepted on that same cycle.
- Wrap: CNT_WIDTH=4, 17 lines -> o_line_count sequence reaches 15 then 0 then 1.
- Reset mid-line: assert i_reset low while in HIGH -> o_valid=0 and o_line_count=0 immediately; after release o_ready=1 and the next line emits its lower half first.
